// File: rtl/lock_key_sender.sv
// lock_key_sender: derives a key/kind from a 4x8 code table, offers it to the lock responder, retries on timeout.
// Latency: start in cycle 0, key_valid in cycle 2, WAIT from cycle 3, earliest done in cycle 4.
// Backpressure: key_o/kind_o are held with key_valid high until key_ready; after that, waits up to TIMEOUT cycles for unlock_i.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   tbl_we/tbl_addr/tbl_wdata code table write port; a write lands only while idle
//   start, busy               sequence launch and in-progress flag
//   kind_o, key_o, key_valid  value offered to the responder, with its valid
//   key_ready                 responder accept
//   unlock_i                  responder unlock indication, looked at only while waiting
//   done, pass, fail, tries   end-of-sequence pulse, sticky result, handshake count

module lock_key_sender #(
   parameter int MAX_TRIES = 3,    // 1..3, fits the 2-bit tries counter
   parameter int TIMEOUT   = 15    // 1..15, fits the 4-bit timer
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tbl_we,
   input  logic [1:0] tbl_addr,
   input  logic [7:0] tbl_wdata,
   input  logic       start,
   output logic       busy,
   output logic [1:0] kind_o,
   output logic [3:0] key_o,
   output logic       key_valid,
   input  logic       key_ready,
   input  logic       unlock_i,
   output logic       done,
   output logic       pass,
   output logic       fail,
   output logic [1:0] tries
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CALC = 3'd1;
   localparam logic [2:0] SEND = 3'd2;
   localparam logic [2:0] WAIT = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [3:0] TMO_LAST  = 4'(TIMEOUT - 1);
   localparam logic [1:0] TRIES_MAX = 2'(MAX_TRIES);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] timer;
   logic [7:0] tbl [4];

   logic [3:0] key_calc;
   logic [1:0] kind_calc;
   logic       handshake;
   logic       timeout_hit;

   // Only entries 1 and 3 feed the key; the rest of the table is held for software.
   logic unused_tbl_bits;
   assign unused_tbl_bits = ^{tbl[0], tbl[2], tbl[1][7:5], tbl[3][7:5]};

   // The 4-bit sum drops the carry on its own, which gives the mod-16 key.
   assign key_calc  = tbl[1][3:0] + tbl[3][3:0];
   assign kind_calc = (tbl[1][4] && tbl[3][4]) ? 2'b10 : 2'b11;

   assign busy        = (state != IDLE);
   assign key_valid   = (state == SEND);
   assign done        = (state == DONE);
   assign handshake   = key_valid && key_ready;
   // An unlock in the last wait cycle still counts as a pass.
   assign timeout_hit = (state == WAIT) && !unlock_i && (timer == TMO_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: state_nxt = SEND;
         SEND: if (handshake) state_nxt = WAIT;
         WAIT: begin
            if (unlock_i) begin
               state_nxt = DONE;
            end else if (timeout_hit) begin
               state_nxt = (tries == TRIES_MAX) ? DONE : SEND;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         timer  <= 4'h0;
         tries  <= 2'd0;
         pass   <= 1'b0;
         fail   <= 1'b0;
         key_o  <= 4'h0;
         kind_o <= 2'b00;
         for (int i = 0; i < 4; i++) begin
            tbl[i] <= 8'h00;
         end
      end else begin
         state <= state_nxt;

         // A write in the same cycle as start lands before CALC reads the table.
         if ((state == IDLE) && tbl_we) begin
            tbl[tbl_addr] <= tbl_wdata;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  pass  <= 1'b0;
                  fail  <= 1'b0;
                  tries <= 2'd0;
               end
            end
            CALC: begin
               key_o  <= key_calc;
               kind_o <= kind_calc;
            end
            SEND: begin
               if (handshake) begin
                  tries <= tries + 2'd1;
                  timer <= 4'h0;
               end
            end
            WAIT: begin
               // The result is set on the way into DONE, so it is visible alongside done.
               if (unlock_i) begin
                  pass <= 1'b1;
               end else if (timeout_hit) begin
                  if (tries == TRIES_MAX) begin
                     fail <= 1'b1;
                  end
               end else begin
                  timer <= timer + 4'h1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
